// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the fetch/data memory arbiter:
//               FSM state enum, grant enum and access-size codes.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } arbState_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_t;

    // Access-size codes, same encoding as the pipeline's sizeSrc
    localparam logic [2:0] c_SIZE_BYTE  = 3'b000;
    localparam logic [2:0] c_SIZE_HALF  = 3'b001;
    localparam logic [2:0] c_SIZE_WORD  = 3'b010;
    localparam logic [2:0] c_SIZE_BYTEU = 3'b100;
    localparam logic [2:0] c_SIZE_HALFU = 3'b101;

    // The port that gets priority after the given port was served
    function automatic grant_t otherPort(input grant_t g);
        return (g == GNT_I) ? GNT_D : GNT_I;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Bundle of the fetch port, data port, shared-memory port and
//               hazard-unit stall signals around the memory arbiter.
//               slave  = arbiter side, master = pipeline/memory side.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    // Fetch port
    logic                  ireq;
    logic [ADDR_WIDTH-1:0] iaddr;
    logic [DATA_WIDTH-1:0] irdata;
    logic                  iready;
    // Data port
    logic                  dreq;
    logic                  dwe;
    logic [ADDR_WIDTH-1:0] daddr;
    logic [DATA_WIDTH-1:0] dwdata;
    logic [2:0]            dsize;
    logic [DATA_WIDTH-1:0] drdata;
    logic                  dready;
    // Shared memory
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [2:0]            mem_size;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ready;
    // Hazard unit
    logic                  stallF;
    logic                  stallD;

    modport slave (
        input  ireq, iaddr, dreq, dwe, daddr, dwdata, dsize, mem_rdata, mem_ready,
        output irdata, iready, drdata, dready, mem_req, mem_we, mem_addr,
               mem_wdata, mem_size, stallF, stallD
    );

    modport master (
        output ireq, iaddr, dreq, dwe, daddr, dwdata, dsize, mem_rdata, mem_ready,
        input  irdata, iready, drdata, dready, mem_req, mem_we, mem_addr,
               mem_wdata, mem_size, stallF, stallD
    );

endinterface
`default_nettype wire

// File: rtl/mem_arbiter_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : arb_pick
// Description : Combinational winner selection between the fetch and data
//               ports. On a contest the pointer decides; otherwise the sole
//               requester wins.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic   ireq,
    input  logic   dreq,
    input  grant_t pointer,
    output grant_t grant
);

    // Pick the winner for this arbitration cycle
    always_comb begin
        grant = GNT_I;
        if (ireq && dreq) begin
            grant = pointer;
        end else if (dreq) begin
            grant = GNT_D;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-port (fetch/data) arbiter onto a single shared memory.
//               IDLE captures the winning request, BUSY holds it on the memory
//               bus until mem_ready, then pulses the granted port's ready.
//               Optional macro MEM_ARB_RR_EN enables round-robin arbitration;
//               without it the data port always wins a contest.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    localparam logic [0:0] c_IDLE = S_IDLE;
    localparam logic [0:0] c_BUSY = S_BUSY;

    logic [0:0]            r_state;
    grant_t                r_gnt;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [2:0]            r_size;

    grant_t                w_ptr;
    grant_t                w_grant;
    logic                  w_anyReq;
    logic                  w_arbitrate;
    logic                  w_busy;
    logic                  w_done;
    logic                  w_iready;
    logic                  w_dready;

    assign w_anyReq    = bus.ireq | bus.dreq;
    assign w_arbitrate = (r_state == c_IDLE) && w_anyReq;

`ifdef MEM_ARB_RR_EN
    grant_t r_ptr;

    // Hand priority to the other port after every grant
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= GNT_D;
        end else if (w_arbitrate) begin
            r_ptr <= otherPort(w_grant);
        end
    end

    assign w_ptr = r_ptr;
`else
    // Data port is the older instruction, so it always wins a contest
    assign w_ptr = GNT_D;
`endif

    arb_pick u_pick (
        .ireq    (bus.ireq),
        .dreq    (bus.dreq),
        .pointer (w_ptr),
        .grant   (w_grant)
    );

    // IDLE/BUSY sequencing and capture of the winning request
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_gnt   <= GNT_I;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_size  <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_anyReq) begin
                        r_state <= c_BUSY;
                        r_gnt   <= w_grant;
                        if (w_grant == GNT_D) begin
                            r_we    <= bus.dwe;
                            r_addr  <= bus.daddr;
                            r_wdata <= bus.dwdata;
                            r_size  <= bus.dsize;
                        end else begin
                            r_we    <= 1'b0;
                            r_addr  <= bus.iaddr;
                            r_wdata <= '0;
                            r_size  <= c_SIZE_WORD;
                        end
                    end
                end
                c_BUSY: begin
                    // Requester may drop req here; the transaction still completes
                    if (bus.mem_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Reset masks the bus and ready outputs even while the state is still BUSY
    assign w_busy   = (r_state == c_BUSY) && !rst;
    assign w_done   = w_busy && bus.mem_ready;
    assign w_iready = w_done && (r_gnt == GNT_I);
    assign w_dready = w_done && (r_gnt == GNT_D);

    assign bus.mem_req   = w_busy;
    assign bus.mem_we    = r_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.mem_size  = r_size;

    assign bus.iready = w_iready;
    assign bus.dready = w_dready;
    assign bus.irdata = w_iready ? bus.mem_rdata : '0;
    assign bus.drdata = w_dready ? bus.mem_rdata : '0;

    assign bus.stallF = bus.ireq & ~w_iready;
    assign bus.stallD = bus.dreq & ~w_dready;

endmodule
`default_nettype wire
